// File: rtl/imem_loader_if.sv
// Bundles the byte-stream input, the instruction-memory write port and the
// loader status outputs of imem_loader. The loader uses the slave modport;
// the side that drives the stream and watches the status uses master.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata,
    input  core_rst,
    input  busy,
    input  done,
    input  err,
    input  words_loaded
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata,
    output core_rst,
    output busy,
    output done,
    output err,
    output words_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives framed program images over a byte stream
//   SYNC, LEN_HI, LEN_LO, 4*LEN data bytes (big-endian words), CSUM
// and writes the words to instruction memory from address 0, holding the core
// in reset until a frame with a good checksum has been loaded.
// Optional build macro LOADER_TIMEOUT_EN: abort a frame into the error state
// after TIMEOUT_CYCLES consecutive idle cycles while a frame is in progress.
module imem_loader #(
  parameter int          ADDR_W         = 10,
  parameter int          DEPTH          = 1024,
  parameter logic [7:0]  SYNC           = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic           clk,
  input  logic           rst,
  imem_loader_if.slave   bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_LEN_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CSUM   = 3'd4;
  localparam logic [2:0] ST_RUN    = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  logic [2:0]        r_state;
  logic [2:0]        w_next;

  logic              r_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_words;
  logic              r_core_rst;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [7:0]        r_len_hi;
  logic [15:0]       r_len;
  logic [7:0]        r_sum;
  logic [23:0]       r_shift;
  logic [1:0]        r_bcnt;

  logic              w_xfer;
  logic              w_is_sync;
  logic              w_in_frame;
  logic [15:0]       w_len_in;
  logic              w_len_big;
  logic [7:0]        w_sum_fin;
  logic              w_sum_ok;
  logic              w_word_end;
  logic              w_last_word;
  logic              w_tmo;

  assign w_xfer      = bus.s_valid & r_ready;
  assign w_is_sync   = (bus.s_data == SYNC);
  assign w_in_frame  = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                       (r_state == ST_DATA)   || (r_state == ST_CSUM);
  assign w_len_in    = {r_len_hi, bus.s_data};
  assign w_len_big   = {1'b0, w_len_in} > 17'(DEPTH);
  assign w_sum_fin   = r_sum + bus.s_data;
  assign w_sum_ok    = (w_sum_fin == 8'h00);
  assign w_word_end  = (r_bcnt == 2'd3);
  assign w_last_word = w_word_end && ((16'(r_words) + 16'd1) == r_len);

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
  logic        r_timeout;

  assign w_tmo = w_in_frame && !w_xfer &&
                 (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter while a frame is open; any transfer restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (!w_in_frame || w_xfer) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end
  end

  // Sticky record that the last abort came from an idle gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else if (w_tmo) begin
      r_timeout <= 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // Next-state decode; nothing advances without a transfer except a timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer && w_is_sync) w_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_xfer) w_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_xfer) begin
          if (w_len_big)              w_next = ST_ERR;
          else if (w_len_in == 16'd0) w_next = ST_CSUM;
          else                        w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_xfer && w_last_word) w_next = ST_CSUM;
      end
      ST_CSUM: begin
        if (w_xfer) w_next = w_sum_ok ? ST_RUN : ST_ERR;
      end
      ST_RUN, ST_ERR: begin
        if (w_xfer && w_is_sync) w_next = ST_LEN_HI;
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_tmo) w_next = ST_ERR;
  end

  // State register and status flags; flags are registered from the next
  // state so core_rst/done/err change glitch-free together with the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b0;
      r_core_rst <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ready    <= 1'b1;
      r_core_rst <= (w_next != ST_RUN);
      r_busy     <= (w_next == ST_LEN_HI) || (w_next == ST_LEN_LO) ||
                    (w_next == ST_DATA)   || (w_next == ST_CSUM);
      r_done     <= (w_next == ST_RUN);
      r_err      <= (w_next == ST_ERR);
    end
  end

  // Header capture and running checksum over LEN_HI, LEN_LO and data bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len_hi <= '0;
      r_len    <= '0;
      r_sum    <= '0;
    end else if (w_xfer) begin
      case (r_state)
        ST_LEN_HI: begin
          r_len_hi <= bus.s_data;
          r_sum    <= bus.s_data;
        end
        ST_LEN_LO: begin
          r_len <= w_len_in;
          r_sum <= w_sum_fin;
        end
        ST_DATA: begin
          r_sum <= w_sum_fin;
        end
        default: ;
      endcase
    end
  end

  // Big-endian word assembly; the first three bytes wait in r_shift and the
  // fourth completes the word straight into the write register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_bcnt  <= '0;
    end else if (w_xfer) begin
      if (r_state == ST_LEN_LO) begin
        r_bcnt <= '0;
      end else if (r_state == ST_DATA) begin
        r_shift <= {r_shift[15:0], bus.s_data};
        r_bcnt  <= r_bcnt + 2'd1;
      end
    end
  end

  // One-cycle write strobe; the word count doubles as the next write address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_words <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_xfer) begin
        if ((r_state == ST_DATA) && w_word_end) begin
          r_we    <= 1'b1;
          r_addr  <= r_words[ADDR_W-1:0];
          r_wdata <= {r_shift, bus.s_data};
          r_words <= r_words + 1'b1;
        end else if (((r_state == ST_IDLE) || (r_state == ST_RUN) ||
                      (r_state == ST_ERR)) && w_is_sync) begin
          r_words <= '0;
        end
      end
    end
  end

  assign bus.s_ready      = r_ready;
  assign bus.imem_we      = r_we;
  assign bus.imem_addr    = r_addr;
  assign bus.imem_wdata   = r_wdata;
  assign bus.core_rst     = r_core_rst;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.words_loaded = r_words;

endmodule
